// File: rtl/myproject_sdiv_26s_13s_seq.sv
// Sequential signed divider, radix-2 non-restoring, C truncation semantics.
// One quotient bit per cycle, then one cycle of sign/remainder correction.
module myproject_sdiv_26s_13s_seq #(
    parameter int unsigned DIVIDEND_W = 26,
    parameter int unsigned DIVISOR_W  = 13
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int unsigned PR_W  = DIVISOR_W + 1;
    localparam int unsigned CNT_W = $clog2(DIVIDEND_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    logic [1:0]            state, state_n;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] qr;
    logic [DIVISOR_W-1:0]  dsr_mag;
    logic [PR_W-1:0]       pr;
    logic                  q_neg, r_neg, dz_p, ovf_p;

    logic                  accept_c;
    logic [DIVIDEND_W-1:0] dvd_mag_c;
    logic [DIVISOR_W-1:0]  dsr_mag_c;
    logic [PR_W-1:0]       dsr_ext_c, pr_sh_c, pr_step_c, pr_fix_c;
    logic [DIVIDEND_W-1:0] q_res_c;
    logic [DIVISOR_W-1:0]  r_res_c;

    // Next-state logic
    always_comb begin
        state_n  = state;
        accept_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c = 1'b1;
                    state_n  = S_CALC;
                end
            end
            S_CALC: if (cnt == '0) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Unsigned negation at full width holds |-2^(W-1)| exactly, so no extra magnitude bit is stored
    always_comb begin
        dvd_mag_c = dividend[DIVIDEND_W-1] ? -dividend : dividend;
        dsr_mag_c = divisor[DIVISOR_W-1]   ? -divisor  : divisor;
        dsr_ext_c = {1'b0, dsr_mag};
        pr_sh_c   = {pr[PR_W-2:0], qr[DIVIDEND_W-1]};
        pr_step_c = pr[PR_W-1] ? (pr_sh_c + dsr_ext_c) : (pr_sh_c - dsr_ext_c);
        pr_fix_c  = pr[PR_W-1] ? (pr + dsr_ext_c) : pr;
        q_res_c   = q_neg ? -qr : qr;
        r_res_c   = DIVISOR_W'(r_neg ? -pr_fix_c : pr_fix_c);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == S_IDLE);
            out_valid <= (state_n == S_DONE);
        end
    end

    // Datapath: shared shift register carries dividend bits out and quotient bits in
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt         <= '0;
            qr          <= '0;
            dsr_mag     <= '0;
            pr          <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_p        <= 1'b0;
            ovf_p       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        cnt         <= CNT_W'(DIVIDEND_W - 1);
                        qr          <= dvd_mag_c;
                        dsr_mag     <= dsr_mag_c;
                        pr          <= '0;
                        q_neg       <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                        r_neg       <= dividend[DIVIDEND_W-1];
                        dz_p        <= (divisor == '0);
                        ovf_p       <= (dividend == Q_MIN) && (divisor == '1);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                S_CALC: begin
                    pr  <= pr_step_c;
                    qr  <= {qr[DIVIDEND_W-2:0], ~pr_step_c[PR_W-1]};
                    cnt <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    if (dz_p) begin
                        quotient  <= r_neg ? Q_MIN : Q_MAX;
                        remainder <= '0;
                    end else if (ovf_p) begin
                        quotient  <= Q_MAX;
                        remainder <= '0;
                    end else begin
                        quotient  <= q_res_c;
                        remainder <= r_res_c;
                    end
                    div_by_zero <= dz_p;
                    overflow    <= ovf_p && !dz_p;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_myproject_sdiv_26s_13s_seq.sv
// Directed and random checks of the sequential signed divider against a C-semantics model.
module tb_myproject_sdiv_26s_13s_seq;

    localparam int DMIN = -33554432;
    localparam int DMAX = 33554431;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] dividend;
    logic [12:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] quotient;
    logic [12:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    myproject_sdiv_26s_13s_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q_of();
        return int'($signed(quotient));
    endfunction

    function automatic int r_of();
        return int'($signed(remainder));
    endfunction

    // One full transaction; hold = cycles out_ready stays low after out_valid
    task automatic run_op(input int dvd, input int dsr, input int hold);
        int eq, er, lat, w;
        int edz, eov;
        edz = 0; eov = 0; er = 0;
        if (dsr == 0) begin
            edz = 1;
            eq  = (dvd < 0) ? DMIN : DMAX;
        end else if (dvd == DMIN && dsr == -1) begin
            eov = 1;
            eq  = DMAX;
        end else begin
            eq = dvd / dsr;
            er = dvd % dsr;
        end
        @(negedge ap_clk);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge ap_clk);
            w++;
        end
        check("in_ready_before", int'(in_ready), 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        dividend  = 26'(dvd);
        divisor   = 13'(dsr);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
        check("latency", lat, 27);
        check("quotient", q_of(), eq);
        check("remainder", r_of(), er);
        check("div_by_zero", int'(div_by_zero), edz);
        check("overflow", int'(overflow), eov);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 26'(i + 77);
            divisor  = 13'(i + 1);
            @(posedge ap_clk);
            #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_ready", int'(in_ready), 0);
            check("hold_q", q_of(), eq);
            check("hold_r", r_of(), er);
            check("hold_flags", int'({div_by_zero, overflow}), (edz << 1) | eov);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("drain_valid", int'(out_valid), 0);
        check("drain_ready", int'(in_ready), 1);
    endtask

    function automatic int pick_dvd();
        logic [25:0] t;
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return -1;
            3: return DMIN;
            4: return DMAX;
            default: begin
                t = 26'($urandom);
                return int'($signed(t));
            end
        endcase
    endfunction

    function automatic int pick_dsr();
        logic [12:0] t;
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return -1;
            3: return -4096;
            4: return 4095;
            default: begin
                t = 13'($urandom);
                return int'($signed(t));
            end
        endcase
    endfunction

    initial begin
        int seen;
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge ap_clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_q", q_of(), 0);
        check("rst_r", r_of(), 0);
        check("rst_flags", int'({div_by_zero, overflow}), 0);
        ap_rst_n = 1'b1;

        run_op(100, 7, 0);
        run_op(-100, 7, 0);
        run_op(100, -7, 0);
        run_op(-100, -7, 0);
        run_op(DMIN, -1, 0);
        run_op(DMIN, 1, 0);
        run_op(DMAX, -4096, 0);
        run_op(5, 0, 0);
        run_op(-5, 0, 0);
        run_op(1000, 3, 10);

        // Reset in the middle of a calculation discards it
        @(negedge ap_clk);
        in_valid = 1'b1;
        dividend = 26'(1000);
        divisor  = 13'(3);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(in_ready), 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ap_clk);
            if (out_valid) seen = 1;
        end
        check("midrst_no_valid", seen, 0);
        check("midrst_q", q_of(), 0);
        check("midrst_r", r_of(), 0);
        run_op(1000, 3, 0);

        for (int n = 0; n < 300; n++) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(pick_dvd(), pick_dsr(), hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
